// File: rtl/sr_bank_sequencer.sv
// sr_bank_sequencer
// Sequences set/clear commands from NREQ requesters onto a bank of NBITS
// clocked SR flip-flops. One command is accepted per divider tick while idle,
// chosen round-robin, and executed as a one-cycle S or R pulse followed by a
// one-cycle ready (and optional error) pulse back to the granted requester.
// A shadow copy of the bank state is kept alongside.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   tick       one-cycle enable strobe from the clock divider
//   req_valid  per-requester command valid
//   req_set    per-requester set flag
//   req_clr    per-requester clear flag
//   req_idx    per-requester target bit, requester i uses [i*IDXW +: IDXW]
//   req_ready  one-cycle completion pulse to the granted requester
//   req_err    one-cycle error pulse, coincident with req_ready
//   sr_s       set pulses to the flip-flop bank
//   sr_r       reset pulses to the flip-flop bank
//   q_shadow   sequencer's copy of the bank state
//   busy       high whenever the sequencer is not idle
module sr_bank_sequencer #(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IDXW  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_set,
    input  logic [NREQ-1:0]        req_clr,
    input  logic [NREQ*IDXW-1:0]   req_idx,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        req_err,
    output logic [NBITS-1:0]       sr_s,
    output logic [NBITS-1:0]       sr_r,
    output logic [NBITS-1:0]       q_shadow,
    output logic                   busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t            r_state, w_state_nx;
    logic [PW-1:0]     r_ptr, w_ptr_nx;
    logic [PW-1:0]     r_gid, w_gid_nx;
    logic              r_set, w_set_nx;
    logic              r_clr, w_clr_nx;
    logic [IDXW-1:0]   r_idx, w_idx_nx;
    logic [NBITS-1:0]  r_sr_s, w_sr_s_nx;
    logic [NBITS-1:0]  r_sr_r, w_sr_r_nx;
    logic [NBITS-1:0]  r_q, w_q_nx;
    logic [NREQ-1:0]   r_ready, w_ready_nx;
    logic [NREQ-1:0]   r_err, w_err_nx;

    logic              w_found;
    logic [PW-1:0]     w_sel;
    logic              w_in_range;
    logic              w_bad;
    logic              w_do_set;
    logic              w_do_clr;
    logic [NBITS-1:0]  w_bit_mask;
    logic [NREQ-1:0]   w_gid_mask;

    // Round-robin pick: first valid requester at or after the pointer.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int off = 0; off < NREQ; off++) begin
            if (!w_found && req_valid[(int'(r_ptr) + off) % NREQ]) begin
                w_found = 1'b1;
                w_sel   = PW'((int'(r_ptr) + off) % NREQ);
            end
        end
    end

    // Classification of the captured command. Both flags set or an index
    // beyond the bank is an error and never drives the bank.
    always_comb begin
        w_in_range = (int'(r_idx) < NBITS);
        w_bad      = (r_set && r_clr) || !w_in_range;
        w_do_set   = r_set && !r_clr && w_in_range;
        w_do_clr   = r_clr && !r_set && w_in_range;
        w_bit_mask = NBITS'(1) << r_idx;
        w_gid_mask = NREQ'(1) << r_gid;
    end

    // Next-state and next-output logic. Pulses default to zero so every
    // S/R, ready and error output lasts exactly one cycle.
    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_gid_nx   = r_gid;
        w_set_nx   = r_set;
        w_clr_nx   = r_clr;
        w_idx_nx   = r_idx;
        w_sr_s_nx  = '0;
        w_sr_r_nx  = '0;
        w_q_nx     = r_q;
        w_ready_nx = '0;
        w_err_nx   = '0;
        case (r_state)
            ST_IDLE: begin
                if (tick && w_found) begin
                    w_gid_nx   = w_sel;
                    w_set_nx   = req_set[w_sel];
                    w_clr_nx   = req_clr[w_sel];
                    w_idx_nx   = req_idx[int'(w_sel)*IDXW +: IDXW];
                    w_ptr_nx   = (int'(w_sel) == NREQ - 1) ? '0 : w_sel + PW'(1);
                    w_state_nx = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_do_set) begin
                    w_sr_s_nx = w_bit_mask;
                end
                if (w_do_clr) begin
                    w_sr_r_nx = w_bit_mask;
                end
                w_state_nx = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (w_do_set) begin
                    w_q_nx = r_q | w_bit_mask;
                end else if (w_do_clr) begin
                    w_q_nx = r_q & ~w_bit_mask;
                end
                w_ready_nx = w_gid_mask;
                w_err_nx   = w_bad ? w_gid_mask : '0;
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any command in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_gid   <= '0;
            r_set   <= 1'b0;
            r_clr   <= 1'b0;
            r_idx   <= '0;
            r_sr_s  <= '0;
            r_sr_r  <= '0;
            r_q     <= '0;
            r_ready <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_gid   <= w_gid_nx;
            r_set   <= w_set_nx;
            r_clr   <= w_clr_nx;
            r_idx   <= w_idx_nx;
            r_sr_s  <= w_sr_s_nx;
            r_sr_r  <= w_sr_r_nx;
            r_q     <= w_q_nx;
            r_ready <= w_ready_nx;
            r_err   <= w_err_nx;
        end
    end

    assign req_ready = r_ready;
    assign req_err   = r_err;
    assign sr_s      = r_sr_s;
    assign sr_r      = r_sr_r;
    assign q_shadow  = r_q;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: doc/sr_bank_sequencer.md
Name: sr_bank_sequencer

Overview:
Sequences set/clear commands from several requesters onto a bank of NBITS clocked SR flip-flops.
- Drives per-bit S/R as one-cycle pulses and guarantees S and R are never both high on any bit.
- Shares the bank between requesters with round-robin arbitration.
- Starts a command only on the tick strobe supplied by the clock divider, and keeps a shadow copy of the bank state.

Parameters:
NREQ, 4, number of requesters.
NBITS, 8, number of SR flip-flops in the bank.
IDXW, 3, width of a bit index; must satisfy 2**IDXW >= NBITS.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
tick  input  1  one-cycle enable strobe from the clock divider.
req_valid  input  NREQ  per-requester command valid.
req_set  input  NREQ  per-requester set flag.
req_clr  input  NREQ  per-requester clear flag.
req_idx  input  NREQ*IDXW  per-requester target bit; requester i uses bits [i*IDXW +: IDXW].
req_ready  output  NREQ  one-cycle completion pulse to the granted requester.
req_err  output  NREQ  one-cycle error pulse, coincident with req_ready.
sr_s  output  NBITS  set pulses to the flip-flop bank.
sr_r  output  NBITS  reset pulses to the flip-flop bank.
q_shadow  output  NBITS  sequencer's copy of the bank state.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, capture registers 0. Reset asserted mid-command aborts it immediately: sr_s and sr_r go to 0 asynchronously and no ready is issued.
- All outputs are registered.
- States: IDLE, GRANT, DRIVE.
- IDLE:
  - When tick=1 and any req_valid=1 at edge k, select the first valid requester at or after the pointer (wrapping NREQ-1 to 0).
  - Capture its set, clr and idx, and its id g. Go to GRANT.
  - Pointer becomes (g+1) mod NREQ.
  - A tick with no valid request does nothing.
- GRANT, at edge k+1, classify the captured command:
  - set=1, clr=0, idx<NBITS: sr_s[idx]=1.
  - clr=1, set=0, idx<NBITS: sr_r[idx]=1.
  - Otherwise no S/R bit is driven.
  - Go to DRIVE.
- DRIVE, at edge k+2:
  - sr_s and sr_r return to 0.
  - q_shadow[idx] is updated: 1 on set, 0 on clear, unchanged otherwise.
  - req_ready[g]=1 for exactly one cycle.
  - Go to IDLE.
- Timing: S/R pulse width is exactly one clk cycle. Latency from the accepting tick edge to the ready pulse is 2 edges. Throughput is at most one command per tick, and at most one per 3 cycles.
- Errors: set=1 and clr=1, or idx>=NBITS, give req_err[g]=1 with req_ready[g]. There is no S/R drive and q_shadow is unchanged.
- No-op: set=0 and clr=0 gives ready without error and no drive; the slot is still consumed and the pointer still advances.
- Handshake:
  - A requester holds valid, set, clr and idx stable until it sees its ready. It may drop valid the cycle after ready.
  - A command is captured at grant. Input changes, or valid dropping after the grant, do not affect the command in flight.
- Ticks arriving while busy=1 are ignored, not queued. A request still valid at the next IDLE tick competes normally.
- Invariant: (sr_s & sr_r) == 0 every cycle, and at most one bit of sr_s|sr_r is high.
- No more than one req_ready bit is high in any cycle.

Test Plan:
1. Reset with rst_n=0 for 3 cycles while requests are pending -> all outputs 0; after release, the first tick with req0 set idx=2 gives sr_s=0x04 one cycle later for one cycle, then q_shadow=0x04 and req_ready=0001.
2. All four requesters valid, each setting its own index 0..3, with ticks every 4 cycles -> grants in order 0,1,2,3 and q_shadow sequence 0x01,0x03,0x07,0x0F; the pointer wraps and a new req0 is served next.
3. req1 with set=1 and clr=1 idx=5 -> sr_s=sr_r=0 throughout; req_ready=0010 and req_err=0010 in the same cycle; q_shadow unchanged.
4. req2 idx=7 set, then req2 idx=7 clr -> sr_r=0x80 one-cycle pulse and q_shadow bit7 goes 1 then 0; req3 with idx=7 and NBITS=6 -> error.
5. tick asserted in the GRANT and DRIVE cycles -> no extra grant; a request that was valid is served at the next IDLE tick.
6. rst_n pulsed low during DRIVE -> sr_s/sr_r drop to 0 immediately, no req_ready, and after release q_shadow=0 and the pointer is 0.
